// File: rtl/batchnorm_normalizer.sv
// rtl/batchnorm_normalizer.sv - batch-norm normalizer: inv_std = 1/sqrt(var+EPS) solver plus y = gamma*(x-mean)*inv_std + beta stream
// Coefficients are recomputed bit-serially in a shadow set, then committed atomically to the active set.
`timescale 1ns/1ps
module batchnorm_normalizer #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int EPS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stats_valid,
  input  logic [WIDTH-1:0] mean_in,
  input  logic [WIDTH-1:0] var_in,
  input  logic [WIDTH-1:0] gamma,
  input  logic [WIDTH-1:0] beta,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_out,
  output logic             busy,
  output logic             coeff_valid
);

  localparam int SQ_CYC = (WIDTH + FRAC + 2) / 2;
  localparam int DV_CYC = 2 * FRAC + 1;
  localparam int RAD_W  = 2 * SQ_CYC;
  localparam int REM_W  = SQ_CYC + 2;
  localparam int CNT_W  = $clog2(((SQ_CYC > DV_CYC) ? SQ_CYC : DV_CYC) + 1);
  localparam int QW     = (DV_CYC > WIDTH) ? DV_CYC : WIDTH + 1;
  localparam int P_W    = 2 * WIDTH + 2;
  localparam int SW     = P_W + WIDTH + 1;

  localparam logic signed [SW-1:0] Y_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] Y_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQRT,
    S_DIV,
    S_COMMIT,
    S_READY
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [RAD_W-1:0]    rad_q;
  logic [REM_W-1:0]    sq_rem_q;
  logic [SQ_CYC-1:0]   root_q;
  logic [SQ_CYC:0]     dv_rem_q;
  logic [DV_CYC-1:0]   quo_q;
  logic                busy_q;
  logic                coeff_valid_q;

  logic [WIDTH-1:0]    mean_s_q, gamma_s_q, beta_s_q;
  logic [WIDTH-1:0]    mean_a_q, gamma_a_q, beta_a_q, inv_a_q;

  logic [RAD_W-1:0]    rad_init;
  logic [REM_W-1:0]    sq_sh, sq_trial, sq_rem_d;
  logic [SQ_CYC-1:0]   root_d;
  logic [SQ_CYC:0]     dv_sh, dv_rem_d;
  logic [DV_CYC-1:0]   quo_d;
  logic [QW-1:0]       quo_ext;
  logic [WIDTH-1:0]    inv_sat;

  assign rad_init = (RAD_W'(var_in) + RAD_W'(EPS)) << FRAC;

  // One root bit per cycle: r = 4r + next two radicand bits, try subtracting 4y+1.
  always_comb begin
    sq_sh    = {sq_rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
    sq_trial = {root_q, 2'b01};
    sq_rem_d = sq_sh;
    root_d   = {root_q[SQ_CYC-2:0], 1'b0};
    if (sq_sh >= sq_trial) begin
      sq_rem_d = sq_sh - sq_trial;
      root_d   = {root_q[SQ_CYC-2:0], 1'b1};
    end
  end

  // Restoring division of 2^(2*FRAC) by the root; the dividend's only set bit enters first.
  always_comb begin
    dv_sh    = {dv_rem_q[SQ_CYC-1:0], (cnt_q == '0)};
    dv_rem_d = dv_sh;
    quo_d    = {quo_q[DV_CYC-2:0], 1'b0};
    if (dv_sh >= {1'b0, root_q}) begin
      dv_rem_d = dv_sh - {1'b0, root_q};
      quo_d    = {quo_q[DV_CYC-2:0], 1'b1};
    end
  end

  always_comb begin
    quo_ext = QW'(quo_q);
    inv_sat = (quo_ext > QW'({WIDTH{1'b1}})) ? {WIDTH{1'b1}} : quo_ext[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rad_q         <= '0;
      sq_rem_q      <= '0;
      root_q        <= '0;
      dv_rem_q      <= '0;
      quo_q         <= '0;
      busy_q        <= 1'b0;
      coeff_valid_q <= 1'b0;
      mean_s_q      <= '0;
      gamma_s_q     <= '0;
      beta_s_q      <= '0;
      mean_a_q      <= '0;
      gamma_a_q     <= '0;
      beta_a_q      <= '0;
      inv_a_q       <= '0;
    end else if (stats_valid) begin
      state_q       <= S_SQRT;
      cnt_q         <= '0;
      rad_q         <= rad_init;
      sq_rem_q      <= '0;
      root_q        <= '0;
      mean_s_q      <= mean_in;
      gamma_s_q     <= gamma;
      beta_s_q      <= beta;
      busy_q        <= 1'b1;
      coeff_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_SQRT: begin
          rad_q    <= rad_q << 2;
          sq_rem_q <= sq_rem_d;
          root_q   <= root_d;
          if (cnt_q == CNT_W'(SQ_CYC - 1)) begin
            state_q  <= S_DIV;
            cnt_q    <= '0;
            dv_rem_q <= '0;
            quo_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DIV: begin
          dv_rem_q <= dv_rem_d;
          quo_q    <= quo_d;
          if (cnt_q == CNT_W'(DV_CYC - 1)) begin
            state_q <= S_COMMIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_COMMIT: begin
          mean_a_q      <= mean_s_q;
          gamma_a_q     <= gamma_s_q;
          beta_a_q      <= beta_s_q;
          inv_a_q       <= inv_sat;
          coeff_valid_q <= 1'b1;
          busy_q        <= 1'b0;
          state_q       <= S_READY;
        end
        default: ;
      endcase
    end
  end

  assign busy        = busy_q;
  assign coeff_valid = coeff_valid_q;

  logic                    en, accept;
  logic                    v0_q, v1_q, out_valid_q;
  logic [WIDTH-1:0]        x_q, y_q;
  logic signed [P_W-1:0]   p_q;

  logic signed [WIDTH:0]   d_s;
  logic signed [P_W-1:0]   prod1, p_d;
  logic signed [SW-1:0]    prod2, q_s, sum_s;
  logic [WIDTH-1:0]        y_d;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = coeff_valid_q && en;
  assign accept   = in_valid && in_ready;

  always_comb begin
    d_s   = $signed({1'b0, x_q}) - $signed({1'b0, mean_a_q});
    prod1 = P_W'(d_s) * P_W'($signed({1'b0, inv_a_q}));
    p_d   = prod1 >>> FRAC;
    prod2 = SW'(p_q) * SW'($signed(gamma_a_q));
    q_s   = prod2 >>> FRAC;
    sum_s = q_s + SW'($signed(beta_a_q));
    y_d   = sum_s[WIDTH-1:0];
    if (sum_s > Y_MAX) begin
      y_d = Y_MAX[WIDTH-1:0];
    end else if (sum_s < Y_MIN) begin
      y_d = Y_MIN[WIDTH-1:0];
    end
  end

  // Whole pipeline advances on one enable so a stalled output freezes every stage in lockstep.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      p_q         <= '0;
      y_q         <= '0;
    end else if (en) begin
      v0_q        <= accept;
      v1_q        <= v0_q;
      out_valid_q <= v1_q;
      if (accept) x_q <= x_in;
      if (v0_q)   p_q <= p_d;
      if (v1_q)   y_q <= y_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y_out     = y_q;

endmodule

// File: tb/tb_batchnorm_normalizer.sv
// tb/tb_batchnorm_normalizer.sv - directed bench for batchnorm_normalizer with expected-output scoreboard
`timescale 1ns/1ps
module tb_batchnorm_normalizer;

  logic        clk = 1'b0;
  logic        rst, stats_valid, in_valid, out_ready;
  logic [15:0] mean_in, var_in, gamma, beta, x_in;
  logic        in_ready, out_valid, busy, coeff_valid;
  logic [15:0] y_out;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] sb[$];

  longint a_mean, a_inv, a_gamma, a_beta;
  longint p_mean, p_inv, p_gamma, p_beta;
  int bad, idx, cyc;
  logic [15:0] xs [8];

  always #5 clk = ~clk;

  batchnorm_normalizer #(.WIDTH(16), .FRAC(8), .EPS(1)) dut (
    .clk(clk), .rst(rst), .stats_valid(stats_valid),
    .mean_in(mean_in), .var_in(var_in), .gamma(gamma), .beta(beta),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
    .busy(busy), .coeff_valid(coeff_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint model_inv(input logic [15:0] v);
    longint r, s, q;
    r = (longint'(v) + 1) << 8;
    s = 0;
    while ((s + 1) * (s + 1) <= r) s++;
    q = (longint'(1) << 16) / s;
    if (q > 65535) q = 65535;
    return q;
  endfunction

  function automatic logic [15:0] model_y(input logic [15:0] x);
    longint d, p, q, y;
    d = longint'(x) - a_mean;
    p = (d * a_inv) >>> 8;
    q = (p * a_gamma) >>> 8;
    y = q + a_beta;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return y[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_stats(input logic [15:0] m, input logic [15:0] v,
                             input logic [15:0] g, input logic [15:0] b, input string tag);
    mean_in = m; var_in = v; gamma = g; beta = b; stats_valid = 1'b1;
    tick();
    stats_valid = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    check({tag, "_cv_drop"}, coeff_valid, 0);
    p_mean = longint'(m); p_inv = model_inv(v);
    p_gamma = longint'($signed(g)); p_beta = longint'($signed(b));
  endtask

  task automatic wait_commit(input string tag);
    int nbad;
    nbad = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (coeff_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) nbad++;
    end
    check({tag, "_compute_window"}, nbad, 0);
    tick();
    check({tag, "_commit_cv"}, coeff_valid, 1);
    check({tag, "_commit_busy"}, busy, 0);
    a_mean = p_mean; a_inv = p_inv; a_gamma = p_gamma; a_beta = p_beta;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] exp_y, input string tag);
    int guard;
    bit acc;
    guard = 0; acc = 1'b0;
    in_valid = 1'b1; x_in = x;
    while (!acc && guard < 50) begin
      #1;
      if (in_ready === 1'b1) begin
        sb.push_back(exp_y);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    check({tag, "_accepted"}, acc, 1);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    check({tag, "_drained"}, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1) begin
      check("output_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        check("y_out", y_out, sb[0]);
        if (out_ready === 1'b1) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stats_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mean_in = '0; var_in = '0; gamma = '0; beta = '0; x_in = '0;
    a_mean = 0; a_inv = 0; a_gamma = 0; a_beta = 0;
    xs = '{16'h0600, 16'h0C00, 16'h0A00, 16'h0FFF, 16'h0000, 16'h0B80, 16'h0900, 16'h2000};
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_cv", coeff_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_y_out", y_out, 0);
    rst = 1'b0;
    tick();

    // T6: no coefficients yet, samples must be refused
    in_valid = 1'b1; x_in = 16'h1234; out_ready = 1'b1; bad = 0;
    repeat (10) begin
      tick();
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    check("t6_idle_refuse", bad, 0);

    // T1
    pulse_stats(16'h0A00, 16'h0400, 16'h0100, 16'h0000, "t1");
    wait_commit("t1");
    check("t1_model_inv", a_inv[15:0], 16'h0080);
    send(16'h0C00, 16'h0100, "t1_a");
    tick();
    check("t1_lat_t1", out_valid, 0);
    tick();
    check("t1_lat_t2", out_valid, 1);
    check("t1_y_a", y_out, 16'h0100);
    send(16'h0800, 16'hFF00, "t1_b");
    drain("t1");

    // T2: saturation both ways
    pulse_stats(16'h0000, 16'h0000, 16'h0100, 16'h0000, "t2a");
    wait_commit("t2a");
    send(16'hFFFF, 16'h7FFF, "t2_pos");
    drain("t2a");
    pulse_stats(16'hFFFF, 16'h0000, 16'h0100, 16'h0000, "t2b");
    wait_commit("t2b");
    send(16'h0000, 16'h8000, "t2_neg");
    drain("t2b");

    // T3: gamma/beta applied, then back-to-back with out_ready toggling
    pulse_stats(16'h0A00, 16'h0400, 16'h0200, 16'h0080, "t3");
    wait_commit("t3");
    send(16'h0C00, 16'h0280, "t3_a");
    drain("t3a");
    idx = 0; cyc = 0;
    while (idx < 8 && cyc < 100) begin
      out_ready = (cyc % 2 == 0);
      in_valid = 1'b1; x_in = xs[idx];
      #1;
      if (in_ready === 1'b1) begin
        sb.push_back(model_y(xs[idx]));
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("t3_stream_count", idx, 8);
    drain("t3b");

    // T4: recompute while two samples are in flight
    pulse_stats(16'h0A00, 16'h0400, 16'h0100, 16'h0000, "t4a");
    wait_commit("t4a");
    send(16'h0C00, model_y(16'h0C00), "t4_x1");
    send(16'h0700, model_y(16'h0700), "t4_x2");
    pulse_stats(16'h0400, 16'h0100, 16'h0180, 16'h0010, "t4b");
    wait_commit("t4b");
    check("t4_in_ready_after", in_ready, 1);
    send(16'h0500, model_y(16'h0500), "t4_x3");
    drain("t4");

    // T5: restart mid-SQRT, then reset mid-DIV with a stalled output
    pulse_stats(16'h0300, 16'h0900, 16'h0100, 16'h0000, "t5a");
    repeat (5) tick();
    check("t5_busy_mid", busy, 1);
    pulse_stats(16'h0200, 16'h0040, 16'hFF00, 16'h0020, "t5b");
    wait_commit("t5b");
    send(16'h0280, model_y(16'h0280), "t5_x1");
    drain("t5");
    out_ready = 1'b0;
    send(16'h0100, model_y(16'h0100), "t5_x2");
    repeat (3) tick();
    check("t5_stalled_valid", out_valid, 1);
    pulse_stats(16'h0000, 16'h0000, 16'h0100, 16'h0000, "t5c");
    repeat (20) tick();
    check("t5_busy_div", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("t5_rst_busy", busy, 0);
    check("t5_rst_cv", coeff_valid, 0);
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_y_out", y_out, 0);
    check("t5_rst_in_ready", in_ready, 0);
    out_ready = 1'b1; bad = 0;
    repeat (35) begin
      tick();
      if (out_valid !== 1'b0 || coeff_valid !== 1'b0) bad++;
    end
    check("t5_stays_reset", bad, 0);

    check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
